// File: rtl/scratch_stack_ram.sv
// Single-port scratch RAM with direct access, a downward-growing stack and a whole-array clear engine.
// Reads (RE/POP) land on DATA_OUT with VALID one cycle later; every command is dropped while the clear runs (BUSY).
module scratch_stack_ram #(
    parameter int DATA_W    = 10,
    parameter int ADDR_W    = 8,
    parameter int INIT_ZERO = 1
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [DATA_W-1:0] DATA_IN,
    input  logic [ADDR_W-1:0] ADDR,
    input  logic              WE,
    input  logic              RE,
    input  logic              PUSH,
    input  logic              POP,
    input  logic              CLR,
    output logic [DATA_W-1:0] DATA_OUT,
    output logic              VALID,
    output logic [ADDR_W-1:0] SP,
    output logic              FULL,
    output logic              EMPTY,
    output logic              BUSY,
    output logic              OVF,
    output logic              UNF
);

    localparam int                DEPTH     = 2 ** ADDR_W;
    localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [DATA_W-1:0] INIT_VAL  = (INIT_ZERO != 0) ? '0 : 'x;

    typedef enum logic {
        IDLE,
        CLEARING
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] caddr;
    logic [ADDR_W:0]   count;

    logic [DATA_W-1:0] mem [DEPTH] = '{default: INIT_VAL};

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdat;

    assign FULL  = (count == DEPTH_CNT);
    assign EMPTY = (count == '0);

    // Array writes are gated by reset so an aborted clear leaves the remaining words untouched.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = '0;
        mem_wdat  = '0;
        if (RST_N) begin
            if (state == CLEARING) begin
                mem_we    = 1'b1;
                mem_waddr = caddr;
            end else if (!CLR && PUSH) begin
                mem_we    = !FULL;
                mem_waddr = SP - ADDR_W'(1);
                mem_wdat  = DATA_IN;
            end else if (!CLR && !POP && WE) begin
                mem_we    = 1'b1;
                mem_waddr = ADDR;
                mem_wdat  = DATA_IN;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdat;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= IDLE;
            caddr    <= '0;
            count    <= '0;
            SP       <= '0;
            DATA_OUT <= '0;
            VALID    <= 1'b0;
            BUSY     <= 1'b0;
            OVF      <= 1'b0;
            UNF      <= 1'b0;
        end else begin
            VALID <= 1'b0;
            case (state)
                IDLE: begin
                    if (CLR) begin
                        state <= CLEARING;
                        caddr <= '0;
                        BUSY  <= 1'b1;
                        SP    <= '0;
                        count <= '0;
                        OVF   <= 1'b0;
                        UNF   <= 1'b0;
                    end else if (PUSH) begin
                        if (FULL) begin
                            OVF <= 1'b1;
                        end else begin
                            SP    <= SP - ADDR_W'(1);
                            count <= count + (ADDR_W + 1)'(1);
                        end
                    end else if (POP) begin
                        if (EMPTY) begin
                            UNF <= 1'b1;
                        end else begin
                            DATA_OUT <= mem[SP];
                            VALID    <= 1'b1;
                            SP       <= SP + ADDR_W'(1);
                            count    <= count - (ADDR_W + 1)'(1);
                        end
                    end else if (!WE && RE) begin
                        DATA_OUT <= mem[ADDR];
                        VALID    <= 1'b1;
                    end
                end
                CLEARING: begin
                    caddr <= caddr + ADDR_W'(1);
                    if (caddr == '1) begin
                        state <= IDLE;
                        BUSY  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_scratch_stack_ram.sv
// Directed plus randomized bench for scratch_stack_ram against an array/counter reference model.
module tb_scratch_stack_ram;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic [9:0] DATA_IN = '0;
    logic [7:0] ADDR = '0;
    logic       WE = 1'b0, RE = 1'b0, PUSH = 1'b0, POP = 1'b0, CLR = 1'b0;
    logic [9:0] DATA_OUT;
    logic       VALID;
    logic [7:0] SP;
    logic       FULL, EMPTY, BUSY, OVF, UNF;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [9:0] ref_mem [256];
    int         m_sp, m_count, m_clr_left;
    bit         m_ovf, m_unf, m_valid;
    logic [9:0] m_dout;

    scratch_stack_ram #(.DATA_W(10), .ADDR_W(8), .INIT_ZERO(1)) dut (
        .CLK(CLK), .RST_N(RST_N), .DATA_IN(DATA_IN), .ADDR(ADDR),
        .WE(WE), .RE(RE), .PUSH(PUSH), .POP(POP), .CLR(CLR),
        .DATA_OUT(DATA_OUT), .VALID(VALID), .SP(SP), .FULL(FULL),
        .EMPTY(EMPTY), .BUSY(BUSY), .OVF(OVF), .UNF(UNF)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("VALID", 32'(VALID), 32'(m_valid));
        chk("DATA_OUT", 32'(DATA_OUT), 32'(m_dout));
        chk("SP", 32'(SP), 32'(m_sp));
        chk("FULL", 32'(FULL), 32'(m_count == 256));
        chk("EMPTY", 32'(EMPTY), 32'(m_count == 0));
        chk("BUSY", 32'(BUSY), 32'(m_clr_left > 0));
        chk("OVF", 32'(OVF), 32'(m_ovf));
        chk("UNF", 32'(UNF), 32'(m_unf));
    endtask

    task automatic model_reset();
        m_sp = 0; m_count = 0; m_clr_left = 0;
        m_ovf = 0; m_unf = 0; m_valid = 0; m_dout = '0;
    endtask

    // One clock: drive, take the edge, advance the model, compare.
    task automatic step(input bit we, input bit re, input bit push, input bit pop,
                        input bit clr, input logic [7:0] a, input logic [9:0] d);
        WE = we; RE = re; PUSH = push; POP = pop; CLR = clr; ADDR = a; DATA_IN = d;
        @(posedge CLK);
        #1;
        m_valid = 0;
        if (m_clr_left > 0) begin
            ref_mem[256 - m_clr_left] = '0;
            m_clr_left--;
        end else if (clr) begin
            m_clr_left = 256; m_sp = 0; m_count = 0; m_ovf = 0; m_unf = 0;
        end else if (push) begin
            if (m_count == 256) m_ovf = 1;
            else begin
                m_sp = (m_sp + 255) % 256;
                ref_mem[m_sp] = d;
                m_count++;
            end
        end else if (pop) begin
            if (m_count == 0) m_unf = 1;
            else begin
                m_dout = ref_mem[m_sp];
                m_valid = 1;
                m_sp = (m_sp + 1) % 256;
                m_count--;
            end
        end else if (we) begin
            ref_mem[a] = d;
        end else if (re) begin
            m_dout = ref_mem[a];
            m_valid = 1;
        end
        WE = 0; RE = 0; PUSH = 0; POP = 0; CLR = 0;
        check_all();
    endtask

    task automatic rd(input logic [7:0] a);
        step(0, 1, 0, 0, 0, a, '0);
    endtask

    task automatic push_v(input logic [9:0] d);
        step(0, 0, 1, 0, 0, '0, d);
    endtask

    task automatic pop_v();
        step(0, 0, 0, 1, 0, '0, '0);
    endtask

    task automatic fill_random();
        for (int i = 0; i < 256; i++) step(1, 0, 0, 0, 0, 8'(i), 10'($urandom_range(1, 1023)));
    endtask

    initial begin
        foreach (ref_mem[i]) ref_mem[i] = '0;
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        check_all();
        @(negedge CLK);
        RST_N = 1'b1;
        @(posedge CLK);
        #1;

        // Direct write then read
        step(1, 0, 0, 0, 0, 8'h05, 10'h3A5);
        rd(8'h05);
        chk("re_0x05", 32'(DATA_OUT), 32'h3A5);

        // Two pushes, two pops
        push_v(10'h001);
        push_v(10'h002);
        chk("sp_after_2push", 32'(SP), 32'hFE);
        rd(8'hFF);
        chk("mem_ff", 32'(DATA_OUT), 32'h001);
        pop_v();
        chk("pop1", 32'(DATA_OUT), 32'h002);
        pop_v();
        chk("pop2", 32'(DATA_OUT), 32'h001);

        // Fill stack, overflow, drain, underflow
        for (int i = 0; i < 256; i++) push_v(10'($urandom_range(0, 1023)));
        chk("full_sp", 32'(SP), 32'h00);
        push_v(10'h155);
        chk("ovf_set", 32'(OVF), 32'h1);
        rd(8'hFF);
        for (int i = 0; i < 256; i++) pop_v();
        pop_v();
        chk("unf_set", 32'(UNF), 32'h1);
        chk("unf_no_valid", 32'(VALID), 32'h0);

        // Priority: PUSH beats POP and WE
        step(0, 0, 1, 1, 1'b0, 8'h10, 10'h000);
        step(1, 0, 1, 1, 0, 8'h10, 10'h111);
        chk("prio_no_valid", 32'(VALID), 32'h0);
        rd(8'h10);

        // Randomized mixed traffic
        for (int i = 0; i < 400; i++) begin
            int unsigned r = $urandom;
            step(r[0], r[1], r[2] & r[5], r[3] & r[6], 1'b0, 8'($urandom), 10'($urandom));
        end

        // Full clear with commands thrown at it while busy
        fill_random();
        step(0, 0, 0, 0, 1, '0, '0);
        for (int i = 0; i < 256; i++) begin
            int unsigned r = $urandom;
            if (i == 5) step(0, 1, 0, 0, 0, 8'h80, '0);
            else step(r[0], r[1], r[2], r[3], r[4], 8'($urandom), 10'($urandom));
        end
        chk("busy_done", 32'(BUSY), 32'h0);
        for (int i = 0; i < 8; i++) begin
            logic [7:0] a;
            a = 8'($urandom);
            rd(a);
            chk("clr_zero", 32'(DATA_OUT), 32'h0);
        end

        // Reset aborts a clear after 100 words
        fill_random();
        step(0, 0, 1, 0, 0, '0, 10'h2AA);
        step(0, 0, 0, 0, 1, '0, '0);
        for (int i = 0; i < 100; i++) step(0, 0, 0, 0, 0, '0, '0);
        RST_N = 1'b0;
        model_reset();
        #1;
        check_all();
        #3;
        RST_N = 1'b1;
        for (int i = 0; i < 256; i++) rd(8'(i));
        rd(8'h63);
        chk("abort_63", 32'(DATA_OUT), 32'h0);
        rd(8'h64);
        chk("abort_64_kept", 32'(DATA_OUT == 0), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/scratch_stack_ram.md
Name: scratch_stack_ram

Overview:
- Parametrised successor to the MCU scratch RAM. Synchronous single-port storage with two access modes: direct-addressed read/write, and push/pop through an internal stack pointer.
- Read data is registered. The block raises a sticky overflow/underflow error on stack misuse.
- A sequential clear engine zeroes the whole array on command.
- Sits between the MCU control unit / ALU result mux and the register file; it replaces the hard-coded 10x256 scratch array and the external SP register.

Parameters:
- DATA_W, 10, data word width in bits.
- ADDR_W, 8, address width. DEPTH = 2**ADDR_W words.
- INIT_ZERO, 1, if 1 the array powers up all-zero in simulation/FPGA init. If 0 the array powers up undefined.

Ports:
- CLK  in  1  rising-edge clock.
- RST_N  in  1  asynchronous, active-low reset.
- DATA_IN  in  DATA_W  write data for WE and PUSH.
- ADDR  in  ADDR_W  direct address for WE and RE.
- WE  in  1  direct write.
- RE  in  1  direct read.
- PUSH  in  1  stack push of DATA_IN.
- POP  in  1  stack pop.
- CLR  in  1  start array clear; single-cycle pulse or level.
- DATA_OUT  out  DATA_W  registered read data.
- VALID  out  1  one-cycle pulse; DATA_OUT updated this cycle.
- SP  out  ADDR_W  current stack pointer.
- FULL  out  1  stack count == DEPTH.
- EMPTY  out  1  stack count == 0.
- BUSY  out  1  clear engine running.
- OVF  out  1  sticky: push attempted while FULL.
- UNF  out  1  sticky: pop attempted while EMPTY.

Behaviour:
- Reset (RST_N low, async): SP=0, internal COUNT=0, DATA_OUT=0, VALID=0, BUSY=0, OVF=0, UNF=0, FSM=IDLE.
  - Array contents are not altered by reset.
  - Reset during CLEARING aborts the clear; words not yet zeroed keep their old values.
- FSM states:
  - IDLE: accepts commands.
  - CLEARING: internal counter CADDR steps 0..DEPTH-1, writing 0 to mem[CADDR] each cycle.
  - IDLE->CLEARING on CLR. On entry: SP=0, COUNT=0, OVF=0, UNF=0, BUSY=1.
  - CLEARING->IDLE after the write at DEPTH-1 (exactly DEPTH cycles in CLEARING). BUSY falls on the first IDLE cycle.
- While BUSY, all of WE/RE/PUSH/POP/CLR are ignored. No flag change, VALID stays 0.
- Command priority in IDLE: CLR > PUSH > POP > WE > RE. Exactly one command executes per cycle; lower-priority commands asserted in the same cycle are dropped.
- Stack grows downward (MCU convention).
  - PUSH: SP <= SP-1 (mod DEPTH), mem[SP-1] <= DATA_IN, COUNT+1. The first push after reset writes address DEPTH-1.
  - POP: DATA_OUT <= mem[SP], SP <= SP+1 (mod DEPTH), COUNT-1, VALID=1 next cycle.
- Error cases:
  - PUSH while FULL: no write, SP/COUNT unchanged, OVF<=1.
  - POP while EMPTY: no read, VALID=0, DATA_OUT held, UNF<=1.
  - OVF and UNF stay set until reset or CLR.
- Direct access does not modify SP or COUNT.
  - WE: mem[ADDR] <= DATA_IN.
  - RE: DATA_OUT <= mem[ADDR], VALID=1 next cycle.
- Latency: RE or POP accepted at edge N produces DATA_OUT/VALID after edge N+1 (one cycle). DATA_OUT holds its last value whenever VALID=0.
- Read-after-write: a PUSH followed immediately by POP returns the pushed value (array written at edge N, read at edge N+1). No bypass is needed.
- COUNT is ADDR_W+1 bits wide. FULL = (COUNT==DEPTH), EMPTY = (COUNT==0); both are combinational from COUNT. SP wraps silently modulo DEPTH.
- CLR asserted during CLEARING is ignored; the clear does not restart.

Test Plan:
- Reset, then WE ADDR=0x05 DATA_IN=0x3A5, then RE ADDR=0x05 -> next cycle VALID=1, DATA_OUT=0x3A5; SP=0, EMPTY=1.
- PUSH 0x001, PUSH 0x002 -> SP=0xFE, mem[0xFF]=0x001, mem[0xFE]=0x002. Then POP, POP -> DATA_OUT=0x002 then 0x001, SP=0x00, EMPTY=1.
- 256 pushes -> FULL=1, SP=0x00. A 257th push -> OVF=1, SP unchanged, mem[0xFF] unchanged. Then POP on empty after draining -> UNF=1, VALID=0.
- PUSH, POP and WE asserted together with DATA_IN=0x111 -> only the push executes: SP-1, COUNT+1, no read pulse, mem[ADDR] unchanged.
- CLR after filling memory -> BUSY=1 for exactly 256 cycles; RE ADDR=0x80 during BUSY gives no VALID; after BUSY=0, RE of any address returns 0, OVF=UNF=0.
- RST_N low at clear cycle 100 -> BUSY=0 immediately, SP=0. mem[0x00..0x63] read 0; mem[0x64..0xFF] keep their prior values.
